// File: rtl/data_mem_arbiter_if.sv
// Bundle of the requester-side handshake signals and the data memory port
// that the arbiter drives. The arbiter connects through the slave modport;
// the requesters and the memory model sit on the master side.
//
// Handshake: a request transfers on a rising edge where req_valid_i[n] and
// req_ready_o[n] are both high. Once valid is raised, the requester holds
// valid, we, adtp, addr and wdata stable until it sees ready. It may drop
// valid before ready, and then no transfer happens. req_ready_o depends
// combinationally on req_valid_i. A response is a single-cycle pulse on
// rsp_valid_o[n]. rsp_rdata_o and rsp_err_o carry meaning only while that
// pulse is high.
interface data_mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [1:0]               req_valid_i;
    logic [1:0]               req_ready_o;
    logic [1:0]               req_we_i;
    logic [1:0]               req_adtp_i;
    logic [ADDRESS_WIDTH-1:0] req_addr0_i;
    logic [ADDRESS_WIDTH-1:0] req_addr1_i;
    logic [DATA_WIDTH-1:0]    req_wdata0_i;
    logic [DATA_WIDTH-1:0]    req_wdata1_i;
    logic [1:0]               rsp_valid_o;
    logic [DATA_WIDTH-1:0]    rsp_rdata_o;
    logic                     rsp_err_o;
    logic [ADDRESS_WIDTH-1:0] mem_a_o;
    logic [DATA_WIDTH-1:0]    mem_wd_o;
    logic                     mem_we_o;
    logic                     mem_adtp_o;
    logic [DATA_WIDTH-1:0]    mem_rd_i;

    modport slave (
        input  req_valid_i, req_we_i, req_adtp_i, req_addr0_i, req_addr1_i,
               req_wdata0_i, req_wdata1_i, mem_rd_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mem_a_o, mem_wd_o, mem_we_o, mem_adtp_o
    );

    modport master (
        output req_valid_i, req_we_i, req_adtp_i, req_addr0_i, req_addr1_i,
               req_wdata0_i, req_wdata1_i, mem_rd_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               mem_a_o, mem_wd_o, mem_we_o, mem_adtp_o
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter for the single data memory port.
// Port 0 is the CPU load/store unit and port 1 is the loader/debug port.
// Each accepted request runs IDLE -> ACCESS -> RESP, one memory access per
// transaction. The design does not pipeline transactions.
module data_mem_arbiter #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] MEM_TOP       = 32'h0001FFFF
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus,
    output logic [1:0]        dbg_state
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // A word access touches addr..addr+3.
    localparam logic [ADDRESS_WIDTH:0] WORD_EXTRA = {{(ADDRESS_WIDTH-1){1'b0}}, 2'b11};

    logic [1:0]               state;
    logic                     last_grant;
    logic                     owner;
    logic                     lat_we;
    logic                     lat_adtp;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic [1:0]               rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_rdata;
    logic                     rsp_err;

    logic                     winner;
    logic [1:0]               ready;
    logic                     in_range;
    logic [ADDRESS_WIDTH:0]   last_byte;

    // Arbitration: a lone valid port wins, and a tie goes to the port that was not granted last.
    always_comb begin
        winner = bus.req_valid_i[1];
        if (bus.req_valid_i == 2'b11) begin
            winner = ~last_grant;
        end
        ready    = 2'b00;
        ready[0] = (state == IDLE) && bus.req_valid_i[0] && !winner;
        ready[1] = (state == IDLE) && bus.req_valid_i[1] && winner;
    end

    // Range check on the latched request, one extra bit so high addresses cannot wrap into range.
    always_comb begin
        last_byte = {1'b0, lat_addr};
        if (!lat_adtp) begin
            last_byte = last_byte + WORD_EXTRA;
        end
        in_range = (last_byte <= {1'b0, MEM_TOP});
    end

    // Transaction FSM: latch on handshake, capture the response in ACCESS, pulse valid in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_we     <= 1'b0;
            lat_adtp   <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 2'b00;
                    if (|ready) begin
                        owner      <= winner;
                        last_grant <= winner;
                        lat_we     <= bus.req_we_i[winner];
                        lat_adtp   <= bus.req_adtp_i[winner];
                        lat_addr   <= winner ? bus.req_addr1_i : bus.req_addr0_i;
                        lat_wdata  <= winner ? bus.req_wdata1_i : bus.req_wdata0_i;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_err   <= ~in_range;
                    rsp_rdata <= (lat_we || !in_range) ? '0 : bus.mem_rd_i;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 2'b00;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // The memory port shows the latched request at all times. Write enable is gated to ACCESS only.
    assign bus.mem_a_o     = lat_addr;
    assign bus.mem_wd_o    = lat_wdata;
    assign bus.mem_adtp_o  = lat_adtp;
    assign bus.mem_we_o    = (state == ACCESS) && lat_we && in_range;

    assign bus.req_ready_o = ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rsp_rdata;
    assign bus.rsp_err_o   = rsp_err;
    assign dbg_state       = state;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter. It provides a byte-addressed memory, drivers
// for the two request ports, a transaction-level model checked on every
// cycle, and directed checks against hand-computed values.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
    localparam int          AW        = 32;
    localparam int          DW        = 32;
    localparam logic [31:0] MEM_TOP   = 32'h0001FFFF;
    localparam int          MEM_BYTES = 32'h20000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] dbg_state;
    data_mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    data_mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEM_TOP(MEM_TOP)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
    );

    // ---------------- requester signals ----------------
    logic        v0 = 1'b0, v1 = 1'b0, we0 = 1'b0, we1 = 1'b0, ad0 = 1'b0, ad1 = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, wd0 = '0, wd1 = '0;
    assign bus.req_valid_i  = {v1, v0};
    assign bus.req_we_i     = {we1, we0};
    assign bus.req_adtp_i   = {ad1, ad0};
    assign bus.req_addr0_i  = a0;
    assign bus.req_addr1_i  = a1;
    assign bus.req_wdata0_i = wd0;
    assign bus.req_wdata1_i = wd1;

    // ---------------- counters / logs ----------------
    int n_chk = 0;
    int n_err = 0;
    logic [1:0]  rq_vld[$];
    logic [31:0] rq_rdata[$];
    logic        rq_err[$];
    int          rq_we[$];
    bit          hs_port[$];
    int          hs_cyc[$];
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic note_timeout(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: event did not occur within its cycle budget at t=%0t", name, $time);
    endtask

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + (i >> 9));
    endfunction

    // ---------------- data memory (environment) ----------------
    logic [7:0]  env_mem [MEM_BYTES];
    logic [16:0] ea0, ea1, ea2, ea3;
    assign ea0 = bus.mem_a_o[16:0];
    assign ea1 = ea0 + 17'd1;
    assign ea2 = ea0 + 17'd2;
    assign ea3 = ea0 + 17'd3;
    assign bus.mem_rd_i = bus.mem_adtp_o ? {24'h0, env_mem[ea0]}
                                         : {env_mem[ea3], env_mem[ea2], env_mem[ea1], env_mem[ea0]};

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) env_mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we_o === 1'b1) begin
                env_mem[ea0] = bus.mem_wd_o[7:0];
                if (!bus.mem_adtp_o) begin
                    env_mem[ea1] = bus.mem_wd_o[15:8];
                    env_mem[ea2] = bus.mem_wd_o[23:16];
                    env_mem[ea3] = bus.mem_wd_o[31:24];
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  ref_mem [MEM_BYTES];
    int          cyc = 0;
    int          m_free = 0, m_acc = -1, m_rsp = -1, we_cnt = 0;
    logic        m_last = 1'b1, m_own = 1'b0, m_we = 1'b0, m_adtp = 1'b0, m_inr = 1'b1, m_err = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [1:0]  idle_code = 2'b00;
    bit          have_code = 1'b0;

    function automatic logic [31:0] read_ref(input logic [31:0] addr, input logic adtp);
        int b;
        b = int'(addr);
        if (adtp) return {24'h0, ref_mem[b]};
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    initial begin
        logic [1:0]  vld, exp_rdy, exp_rv;
        logic [63:0] end_a;
        bit          idle;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
        forever begin
            @(negedge clk);
            cyc++;
            vld     = bus.req_valid_i;
            idle    = (cyc >= m_free);
            exp_rdy = 2'b00;
            if (idle) exp_rdy = (vld == 2'b11) ? (m_last ? 2'b01 : 2'b10) : vld;
            exp_rv  = (cyc == m_rsp) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
            chk("req_ready", 32'(bus.req_ready_o), 32'(exp_rdy));
            if (have_code) chk("state_idle", 32'(dbg_state == idle_code), 32'(idle));
            chk("mem_we", 32'(bus.mem_we_o), 32'((cyc == m_acc) && m_we && m_inr));
            chk("mem_a", bus.mem_a_o, m_addr);
            chk("mem_wd", bus.mem_wd_o, m_wdata);
            chk("mem_adtp", 32'(bus.mem_adtp_o), 32'(m_adtp));
            chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(exp_rv));
            chk("rsp_rdata", bus.rsp_rdata_o, m_rdata);
            chk("rsp_err", 32'(bus.rsp_err_o), 32'(m_err));
            if (bus.mem_we_o === 1'b1) we_cnt++;
            if (bus.rsp_valid_o != 2'b00) begin
                rq_vld.push_back(bus.rsp_valid_o);
                rq_rdata.push_back(bus.rsp_rdata_o);
                rq_err.push_back(bus.rsp_err_o);
                rq_we.push_back(we_cnt);
            end
            if (cyc == m_acc) begin
                m_err = !m_inr;
                if (m_we) begin
                    m_rdata = '0;
                    if (m_inr) begin
                        ref_mem[int'(m_addr)] = m_wdata[7:0];
                        if (!m_adtp) begin
                            ref_mem[int'(m_addr)+1] = m_wdata[15:8];
                            ref_mem[int'(m_addr)+2] = m_wdata[23:16];
                            ref_mem[int'(m_addr)+3] = m_wdata[31:24];
                        end
                    end
                end else begin
                    m_rdata = m_inr ? read_ref(m_addr, m_adtp) : 32'h0;
                end
            end
            if (rst) begin
                m_free = 0; m_acc = -1; m_rsp = -1; m_last = 1'b1; m_own = 1'b0;
                m_we = 1'b0; m_adtp = 1'b0; m_inr = 1'b1; m_err = 1'b0;
                m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else if ((exp_rdy & vld) != 2'b00) begin
                m_own   = exp_rdy[1];
                m_last  = m_own;
                m_we    = bus.req_we_i[m_own];
                m_adtp  = bus.req_adtp_i[m_own];
                m_addr  = m_own ? bus.req_addr1_i : bus.req_addr0_i;
                m_wdata = m_own ? bus.req_wdata1_i : bus.req_wdata0_i;
                end_a   = {32'h0, m_addr} + (m_adtp ? 64'd0 : 64'd3);
                m_inr   = (end_a <= {32'h0, MEM_TOP});
                m_acc   = cyc + 1;
                m_rsp   = cyc + 2;
                m_free  = cyc + 3;
                we_cnt  = 0;
                hs_port.push_back(m_own);
                hs_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic we, input logic ad,
                            input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin v0 = 1'b1; we0 = we; ad0 = ad; a0 = a; wd0 = wd; end
        else        begin v1 = 1'b1; we1 = we; ad1 = ad; a1 = a; wd1 = wd; end
    endtask

    task automatic drop(input int p);
        if (p == 0) v0 = 1'b0;
        else        v1 = 1'b0;
    endtask

    // Entered and left just after a rising edge. On return the port has
    // either completed a handshake at the last edge or withdrawn after
    // 'hold' cycles (hold = 0 means wait for ready).
    task automatic drive(input int p, input logic we, input logic ad, input logic [31:0] a,
                         input logic [31:0] wd, input int hold, output bit got);
        int waited = 0;
        got = 1'b0;
        set_port(p, we, ad, a, wd);
        while (!got) begin
            @(negedge clk);
            if (bus.req_ready_o[p] === 1'b1) got = 1'b1;
            else begin
                waited++;
                if (hold > 0 && waited >= hold) break;
                if (waited >= 60) begin note_timeout("ready_timeout"); break; end
            end
        end
        @(posedge clk); #1;
        if (!got) drop(p);
    endtask

    task automatic wait_rsp(input int base);
        int n = 0;
        while (rq_vld.size() <= base && n < 20) begin @(negedge clk); n++; end
        if (rq_vld.size() <= base) note_timeout("rsp_timeout");
    endtask

    task automatic txn(input int p, input logic we, input logic ad, input logic [31:0] a,
                       input logic [31:0] wd, output int idx);
        bit got;
        idx = rq_vld.size();
        drive(p, we, ad, a, wd, 0, got);
        drop(p);
        wait_rsp(idx);
        @(posedge clk); #1;
    endtask

    task automatic chk_rsp(input int idx, input string name, input logic [1:0] vld,
                           input logic [31:0] rdata, input logic err, input int wes);
        if (rq_vld.size() > idx) begin
            chk({name, "_port"}, 32'(rq_vld[idx]), 32'(vld));
            chk({name, "_rdata"}, rq_rdata[idx], rdata);
            chk({name, "_err"}, 32'(rq_err[idx]), 32'(err));
            chk({name, "_we_pulses"}, 32'(rq_we[idx]), 32'(wes));
        end
    endtask

    task automatic burst(input int p);
        bit got;
        for (int k = 0; k < 4; k++) begin
            drive(p, 1'b0, 1'b0, 32'h00000100 + 32'(k * 4) + (p == 1 ? 32'h40 : 32'h0), 32'h0, 0, got);
        end
        drop(p);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h00010000 + 32'($urandom_range(0, 15));
            1:       return 32'h0001FFF8 + 32'($urandom_range(0, 7));
            2:       return 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            default: return 32'($urandom_range(0, 32'h0001FFFF));
        endcase
    endfunction

    task automatic rand_stream(input int p, input int count);
        bit got;
        int hold;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), $urandom, hold, got);
            drop(p);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int idx, hb, rb;
        bit got;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        chk("reset_rsp_rdata", bus.rsp_rdata_o, 32'h0);
        chk("reset_rsp_err", 32'(bus.rsp_err_o), 32'h0);
        chk("reset_mem_we", 32'(bus.mem_we_o), 32'h0);
        chk("reset_mem_a", bus.mem_a_o, 32'h0);
        chk("reset_mem_wd", bus.mem_wd_o, 32'h0);
        idle_code = dbg_state;
        have_code = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // contention straight out of reset
        hb = hs_port.size();
        fork
            burst(0);
            burst(1);
        join
        repeat (6) begin @(posedge clk); #1; end
        for (int k = 0; k < 8; k++) exp_q.push_back(DW'(k % 2));
        chk("grant_count", 32'(hs_port.size() - hb), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (hs_port.size() > hb + k) begin
                chk("grant_order", 32'(hs_port[hb+k]), exp_q[k]);
                if (k > 0) chk("grant_spacing", 32'(hs_cyc[hb+k] - hs_cyc[hb+k-1]), 32'd3);
            end
        end

        // word store / load and byte load
        txn(0, 1'b1, 1'b0, 32'h00010000, 32'hDEADBEEF, idx);
        chk_rsp(idx, "store_word", 2'b01, 32'h0, 1'b0, 1);
        txn(0, 1'b0, 1'b0, 32'h00010000, 32'h0, idx);
        chk_rsp(idx, "load_word", 2'b01, 32'hDEADBEEF, 1'b0, 0);
        txn(1, 1'b0, 1'b1, 32'h00010001, 32'h0, idx);
        chk_rsp(idx, "load_byte_p1", 2'b10, 32'h000000BE, 1'b0, 0);

        // range boundaries
        txn(0, 1'b1, 1'b0, 32'h0001FFFC, 32'hCAFEF00D, idx);
        chk_rsp(idx, "store_top_word", 2'b01, 32'h0, 1'b0, 1);
        txn(0, 1'b1, 1'b0, 32'h0001FFFD, 32'h11223344, idx);
        chk_rsp(idx, "store_over_word", 2'b01, 32'h0, 1'b1, 0);
        txn(1, 1'b1, 1'b1, 32'h0001FFFF, 32'h000000A5, idx);
        chk_rsp(idx, "store_top_byte", 2'b10, 32'h0, 1'b0, 1);
        txn(0, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0, idx);
        chk_rsp(idx, "load_wrap_word", 2'b01, 32'h0, 1'b1, 0);
        txn(0, 1'b0, 1'b0, 32'h0001FFFC, 32'h0, idx);
        chk_rsp(idx, "load_top_word", 2'b01, 32'hA5FEF00D, 1'b0, 0);
        txn(1, 1'b0, 1'b1, 32'h0001FFFF, 32'h0, idx);
        chk_rsp(idx, "load_top_byte", 2'b10, 32'h000000A5, 1'b0, 0);

        // port 1 raises valid only while port 0 owns the memory
        rb = rq_vld.size();
        hb = hs_port.size();
        drive(0, 1'b0, 1'b0, 32'h00010000, 32'h0, 0, got);
        drop(0);
        set_port(1, 1'b1, 1'b0, 32'h00010004, 32'h55555555);
        @(posedge clk); #1;
        drop(1);
        wait_rsp(rb);
        repeat (6) @(negedge clk);
        chk("withdraw_rsp_count", 32'(rq_vld.size() - rb), 32'd1);
        chk("withdraw_hs_count", 32'(hs_port.size() - hb), 32'd1);
        chk_rsp(rb, "withdraw_p0", 2'b01, 32'hDEADBEEF, 1'b0, 0);
        @(posedge clk); #1;

        // reset during ACCESS of a store: write lands, response is dropped
        rb = rq_vld.size();
        drive(0, 1'b1, 1'b0, 32'h00000200, 32'h12345678, 0, got);
        drop(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
        chk("rst_mem_contents", {env_mem[32'h203], env_mem[32'h202], env_mem[32'h201], env_mem[32'h200]},
            32'h12345678);
        repeat (5) @(negedge clk);
        chk("rst_no_rsp", 32'(rq_vld.size() - rb), 32'd0);
        @(posedge clk); #1;
        hb = hs_port.size();
        fork
            begin bit g; drive(0, 1'b0, 1'b0, 32'h00000200, 32'h0, 0, g); drop(0); end
            begin bit g; drive(1, 1'b0, 1'b1, 32'h00000201, 32'h0, 0, g); drop(1); end
        join
        repeat (6) begin @(posedge clk); #1; end
        if (hs_port.size() > hb) chk("rst_tie_winner", 32'(hs_port[hb]), 32'd0);
        else note_timeout("rst_tie_handshake");

        // randomized traffic on both ports
        fork
            rand_stream(0, 60);
            rand_stream(1, 60);
        join
        repeat (8) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single byte-addressed data memory port (A, WD, WE, ADTP, RD) between two requesters: port 0 is the CPU load/store unit, port 1 is the program/data loader or debug port.
- Each request uses a valid/ready handshake. The arbiter latches the winning request, performs one memory access, then returns a one-cycle response pulse to the winning port.
- The block sits between the requesters and the data memory. It owns the memory's WE, A, WD and ADTP inputs.

Parameters:
- ADDRESS_WIDTH, 32, width of the address buses.
- DATA_WIDTH, 32, width of the data buses.
- MEM_TOP, 32'h0001FFFF, highest valid byte address in data memory.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  2  per-port request valid; bit n belongs to port n.
- req_ready_o  out  2  per-port accept; request transfers when valid&ready are both high.
- req_we_i  in  2  per-port write enable (1 = store, 0 = load).
- req_adtp_i  in  2  per-port access type (0 = 32-bit word, 1 = byte, zero-extended on read).
- req_addr0_i / req_addr1_i  in  ADDRESS_WIDTH each  byte address for port 0 / port 1.
- req_wdata0_i / req_wdata1_i  in  DATA_WIDTH each  store data for port 0 / port 1.
- rsp_valid_o  out  2  one-cycle response pulse to the port that owns the transaction.
- rsp_rdata_o  out  DATA_WIDTH  load data; shared by both ports, qualified by rsp_valid_o.
- rsp_err_o  out  1  access was out of range; qualified by rsp_valid_o.
- mem_a_o  out  ADDRESS_WIDTH  data memory address.
- mem_wd_o  out  DATA_WIDTH  data memory write data.
- mem_we_o  out  1  data memory write enable.
- mem_adtp_o  out  1  data memory access type.
- mem_rd_i  in  DATA_WIDTH  data memory read data (combinational read).

Behaviour:
- Reset values: state=IDLE, last_grant=1, all latched request registers=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_we_o=0, mem_a_o=0, mem_wd_o=0, mem_adtp_o=0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Every transaction takes exactly 3 cycles; no back-to-back pipelining.
- IDLE:
  - req_ready_o is combinational: port n is ready only if state=IDLE, req_valid_i[n]=1, and port n wins arbitration.
  - Only one port may be ready in any cycle.
  - On handshake, latch owner, we, adtp, addr and wdata, then go to ACCESS.
- Arbitration:
  - A single valid port wins.
  - If both ports are valid, the port other than last_grant wins (round-robin).
  - After reset, port 0 wins the first tie.
  - last_grant updates to the owner on the handshake.
- Range check, computed from the latched request:
  - In range when addr <= MEM_TOP for a byte access, or addr+3 <= MEM_TOP for a word access.
  - The sum is computed at ADDRESS_WIDTH+1 bits so that 32'hFFFFFFFD and above do not wrap into range.
- ACCESS:
  - mem_a_o, mem_wd_o and mem_adtp_o present the latched values.
  - mem_we_o = latched we AND in_range, asserted for this single cycle only.
  - On a read, capture mem_rd_i into rsp_rdata_o at the end of this cycle, or 0 if out of range.
  - On a write, rsp_rdata_o is set to 0.
  - rsp_err_o = NOT in_range. Then go to RESP.
- RESP:
  - rsp_valid_o[owner]=1 for exactly one cycle.
  - rsp_rdata_o and rsp_err_o hold their values until the next ACCESS.
  - Return to IDLE; a new handshake is possible in the following cycle.
- mem_a_o, mem_wd_o and mem_adtp_o hold the last latched values outside ACCESS. mem_we_o is 0 outside ACCESS.
- Latency: handshake in cycle N, memory write/read in N+1, rsp_valid_o in N+2. Maximum throughput is 1 transaction per 3 cycles.
- Requesters must hold valid, addr, wdata, we and adtp stable until ready is seen. Dropping valid before ready is permitted; no transaction occurs in that case.
- Reset mid-transaction: the FSM returns to IDLE at the reset edge, with no write (mem_we_o=0 from that edge) and no rsp_valid_o. The pending transaction is discarded and last_grant=1.
- Out-of-range store: no memory write, rsp_err_o=1. Out-of-range load: rsp_rdata_o=0, rsp_err_o=1.
- Misaligned word addresses are legal and passed through unchanged; the memory handles byte lanes.

Test Plan:
- Word store then load, port 0: store addr=0x00010000, wdata=0xDEADBEEF, we=1, adtp=0 -> mem_we_o high for exactly 1 cycle at N+1, rsp_valid_o=2'b01 at N+2. A following load at the same address -> rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
- Byte load, port 1: after storing 0xDEADBEEF at 0x00010000, load addr=0x00010001, adtp=1 -> rsp_rdata_o=0x000000BE, rsp_valid_o=2'b10.
- Contention: both ports valid continuously from reset, each issuing 4 requests -> grants alternate 0,1,0,1,... and each handshake is spaced exactly 3 cycles apart.
- Range boundary:
  - Word store at 0x0001FFFC -> written, err=0.
  - Word store at 0x0001FFFD -> mem_we_o never high, rsp_err_o=1.
  - Byte store at 0x0001FFFF -> written.
  - Word load at 0xFFFFFFFE -> rsp_rdata_o=0, err=1.
- Reset during ACCESS of a store: rst=1 in that cycle -> mem_we_o=0 after the edge, no rsp_valid_o. The memory contents at that address are unchanged only if rst is asserted before ACCESS; otherwise the write completes in ACCESS and the response is dropped. The next request after reset is granted to port 0 on a tie.
- Valid withdrawn: port 1 asserts valid while port 0 owns a transaction, then deasserts before ready -> no port 1 transaction and no port 1 response.
